neuron_mac: RTL and testbench
=============================

# neuron_mac

Sequential multiply-accumulate stage for one neuron. It streams NUM_INPUTS (activation, weight) pairs through a valid/ready handshake, adds a bias, and rescales the signed fixed-point sum back to WORD_LENGTH with saturation. It then presents the result on `out` and fires a one-cycle `ready` strobe. Its `out`/`ready` pair feeds the activation (ReLU) stage directly, which samples `out` on the rising edge of `ready`.

## Interface
- WORD_LENGTH, 16, width of data, weight, bias and result (two's-complement fixed point).
- FRAC_BITS, 8, fractional bits of every operand and of the result (Q8.8 at defaults).
- NUM_INPUTS, 4, pairs accumulated per neuron; must be ≥1.
- ACC_WIDTH, 40, accumulator width; must be ≥ 2*WORD_LENGTH + clog2(NUM_INPUTS) + 1.
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a neuron; sampled only in IDLE.
- bias  input  WORD_LENGTH  signed bias; captured on the accepted start.
- in_valid  input  1  in_data/in_weight valid.
- in_data  input  WORD_LENGTH  signed activation.
- in_weight  input  WORD_LENGTH  signed weight.
- in_ready  output  1  beat accepted when in_valid && in_ready at a clk edge.
- busy  output  1  high in every state except IDLE.
- out  output  WORD_LENGTH  saturated signed result; held until the next result is written.
- ready  output  1  one-cycle strobe, high only while `out` is stable and valid.

## Operation
- States: IDLE, ACC, SAT, FIRE.
- IDLE:
  - On start: acc <= sign_extend(bias) <<< FRAC_BITS and count <= 0.
  - Go to ACC.
- ACC:
  - in_ready = 1 (combinational decode of state).
  - On an accepted beat: acc <= acc + sign_extend(in_data*in_weight), with the full 2*WORD_LENGTH signed product; count <= count+1.
  - The beat with count == NUM_INPUTS-1 moves to SAT.
  - Cycles with in_valid low are bubbles: no change.
- SAT:
  - out <= saturate(acc >>> FRAC_BITS). The shift is arithmetic and truncates toward −∞.
  - Clamp to [−2^(WORD_LENGTH−1), 2^(WORD_LENGTH−1)−1].
  - Go to FIRE.
- FIRE: go to IDLE.
- `ready` is a register, updated as ready <= (state == FIRE). It is therefore high for exactly the one cycle after FIRE.
- start outside IDLE is ignored. in_valid outside ACC is ignored (in_ready = 0).
- A start in the IDLE cycle where ready is high is accepted normally.
- Reset (any time, including mid-accumulation):
  - out = 0, ready = 0, in_ready = 0, busy = 0.
  - acc = 0, count = 0, state = IDLE.
  - Any partial sum is discarded.

## Timing
- Edge 0: start sampled in IDLE.
- Edges 1..N: beats. With no bubbles, the last beat is at edge N = NUM_INPUTS.
- Edge N+1: `out` written (SAT→FIRE).
- Edge N+2: ready rises (FIRE→IDLE).
- Edge N+3: ready falls; the earliest next start is accepted.
- `out` is stable for ≥1 full cycle before ready rises and stays stable while ready is high. There is no race with the downstream posedge-ready sampling.
- Each bubble cycle delays every later edge by one.
- Minimum throughput: one neuron per NUM_INPUTS+3 cycles.

## Structure
- Shared package `nn_pkg` holds:
  - the state enum (IDLE, ACC, SAT, FIRE);
  - default WORD_LENGTH/FRAC_BITS constants, shared with the activation stage;
  - a Q-format saturation helper.
- One sub-module, `fx_sat_shift`: combinational ACC_WIDTH → WORD_LENGTH arithmetic shift plus clamp. It is reused later by other layers.

## Test plan
All scenarios use the defaults (Q8.8, NUM_INPUTS=4).
- Basic:
  - Stimulus: bias 0x0000; four beats of data 0x0100, weight 0x0100, back-to-back.
  - Required: out = 0x0400 written at edge 5; ready high for the single cycle after edge 6; in_ready low outside ACC.
- Negative:
  - Stimulus: bias 0xFF00; four beats of 0x0080 × 0xFF00.
  - Required: out = 0xFD00 (−3.0).
- Saturation:
  - Stimulus: four beats of 0x7FFF × 0x7FFF.
  - Required: out = 0x7FFF.
  - Stimulus: four beats of 0x7FFF × 0x8000.
  - Required: out = 0x8000.
- Truncation:
  - Stimulus: four beats of 0x0001 × 0x0001.
  - Required: out = 0x0000.
  - Stimulus: four beats of 0xFFFF × 0x0001.
  - Required: out = 0xFFFF (floor of −4/256).
- Handshake:
  - Stimulus: in_valid toggled 1,0,1,0,… and start pulsed during ACC.
  - Required: same result as Basic; ready delayed by exactly the bubble count; the extra start is ignored.
- Reset mid-operation:
  - Stimulus: rst_n low after 2 accepted beats, asynchronously mid-cycle.
  - Required: out, ready, in_ready and busy go to 0 immediately. A following full Basic sequence yields 0x0400, with no carry-over.

Source files
------------

// File: rtl/nn_pkg.sv
// Types and helpers shared by the neuron datapath stages (MAC, activation, later layers).
package nn_pkg;

  localparam int unsigned NN_WORD_LENGTH = 16;
  localparam int unsigned NN_FRAC_BITS   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    SAT  = 2'd2,
    FIRE = 2'd3
  } mac_state_e;

  // Clamp a sign-extended value into the signed range of a wl-bit word (wl <= 64).
  function automatic logic signed [63:0] q_sat(input logic signed [63:0] v,
                                               input int unsigned wl);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (wl - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (wl - 1));
    if (v > max_v)      q_sat = max_v;
    else if (v < min_v) q_sat = min_v;
    else                q_sat = v;
  endfunction

endpackage

// File: rtl/fx_sat_shift.sv
// Fixed-point rescale: arithmetic right shift (floor) of a wide sum, then clamp to OUT_W.
module fx_sat_shift
  import nn_pkg::*;
#(
  parameter int unsigned IN_W  = 40,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned SHIFT = 8
) (
  input  logic [IN_W-1:0]  in_val,
  output logic [OUT_W-1:0] out_val
);

  logic signed [IN_W-1:0] shifted;
  logic signed [63:0]     wide;
  logic signed [63:0]     clamped;

  always_comb begin
    shifted = $signed(in_val) >>> SHIFT;
    wide    = 64'(shifted);
    clamped = q_sat(wide, OUT_W);
    out_val = clamped[OUT_W-1:0];
  end

endmodule

// File: rtl/neuron_mac.sv
// Sequential multiply-accumulate for one neuron: bias + sum(data*weight), rescaled and saturated.
module neuron_mac
  import nn_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = NN_WORD_LENGTH,
  parameter int unsigned FRAC_BITS   = NN_FRAC_BITS,
  parameter int unsigned NUM_INPUTS  = 4,
  parameter int unsigned ACC_WIDTH   = 40
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WORD_LENGTH-1:0] bias,
  input  logic                   in_valid,
  input  logic [WORD_LENGTH-1:0] in_data,
  input  logic [WORD_LENGTH-1:0] in_weight,
  output logic                   in_ready,
  output logic                   busy,
  output logic [WORD_LENGTH-1:0] out,
  output logic                   ready
);

  localparam int unsigned CNT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_INPUTS - 1);

  mac_state_e             state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [WORD_LENGTH-1:0] out_q, out_d;
  logic                   ready_q, ready_d;

  logic signed [2*WORD_LENGTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]     bias_ext;
  logic [WORD_LENGTH-1:0]          sat_val;

  fx_sat_shift #(
    .IN_W  (ACC_WIDTH),
    .OUT_W (WORD_LENGTH),
    .SHIFT (FRAC_BITS)
  ) u_sat (
    .in_val  (acc_q),
    .out_val (sat_val)
  );

  always_comb begin
    prod     = $signed(in_data) * $signed(in_weight);
    bias_ext = ACC_WIDTH'($signed(bias)) <<< FRAC_BITS;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    out_d   = out_q;
    ready_d = (state_q == FIRE);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = bias_ext;
          count_d = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        if (in_valid) begin
          acc_d   = ACC_WIDTH'($signed(acc_q) + ACC_WIDTH'(prod));
          count_d = count_q + 1'b1;
          if (count_q == LAST_CNT) state_d = SAT;
        end
      end
      SAT: begin
        out_d   = sat_val;
        state_d = FIRE;
      end
      FIRE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      out_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      out_q   <= out_d;
      ready_q <= ready_d;
    end
  end

  assign in_ready = (state_q == ACC);
  assign busy     = (state_q != IDLE);
  assign out      = out_q;
  assign ready    = ready_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac at Q8.8, NUM_INPUTS=4.
module tb_neuron_mac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] bias;
  logic        in_valid;
  logic [15:0] in_data;
  logic [15:0] in_weight;
  logic        in_ready;
  logic        busy;
  logic [15:0] out;
  logic        ready;

  int checks = 0;
  int errors = 0;
  logic [15:0] prev_out = 16'h0000;

  neuron_mac #(
    .WORD_LENGTH (16),
    .FRAC_BITS   (8),
    .NUM_INPUTS  (4),
    .ACC_WIDTH   (40)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_weight (in_weight),
    .in_ready  (in_ready),
    .busy      (busy),
    .out       (out),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full neuron: start, four beats (optionally separated by bubbles), then result/strobe timing.
  task automatic run_neuron(input string name, input logic [15:0] b, input logic [15:0] d,
                            input logic [15:0] w, input bit bub, input bit xstart,
                            input logic [15:0] exp);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL %s idle_in_ready: got %b want 0", name, in_ready); end
    start = 1'b1; bias = b;
    step();
    start = 1'b0; bias = 16'h5A5A;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL %s acc_entry: in_ready=%b busy=%b want 1 1", name, in_ready, busy);
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = d; in_weight = w;
      step();
      if (bub && i < 3) begin
        in_valid = 1'b0; in_data = 16'hAAAA; in_weight = 16'h7777; start = xstart; bias = 16'h7F00;
        step();
        start = 1'b0;
      end
    end
    in_valid = 1'b0; in_data = 16'h0000; in_weight = 16'h0000;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || ready !== 1'b0 || out !== prev_out) begin
      errors++;
      $display("FAIL %s sat_state: busy=%b in_ready=%b ready=%b out=%h want 1 0 0 %h",
               name, busy, in_ready, ready, out, prev_out);
    end
    step();
    checks++;
    if (out !== exp || ready !== 1'b0) begin
      errors++; $display("FAIL %s out_write: out=%h ready=%b want %h 0", name, out, ready, exp);
    end
    step();
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || out !== exp) begin
      errors++; $display("FAIL %s ready_strobe: ready=%b busy=%b out=%h want 1 0 %h", name, ready, busy, out, exp);
    end
    step();
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL %s ready_fall: got %b want 0", name, ready); end
    prev_out = exp;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; bias = '0; in_valid = 1'b0; in_data = '0; in_weight = '0;
    #12;
    checks++;
    if (out !== 16'h0000 || ready !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out=%h ready=%b in_ready=%b busy=%b want 0000 0 0 0", out, ready, in_ready, busy);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    run_neuron("basic", 16'h0000, 16'h0100, 16'h0100, 1'b0, 1'b0, 16'h0400);
  endtask

  task automatic test_negative();
    run_neuron("negative", 16'hFF00, 16'h0080, 16'hFF00, 1'b0, 1'b0, 16'hFD00);
  endtask

  task automatic test_saturation();
    run_neuron("sat_pos", 16'h0000, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 16'h7FFF);
    run_neuron("sat_neg", 16'h0000, 16'h7FFF, 16'h8000, 1'b0, 1'b0, 16'h8000);
  endtask

  task automatic test_truncation();
    run_neuron("trunc_pos", 16'h0000, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0000);
    run_neuron("trunc_neg", 16'h0000, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'hFFFF);
  endtask

  task automatic test_handshake();
    // Beat offered while idle must be ignored.
    in_valid = 1'b1; in_data = 16'h4000; in_weight = 16'h4000;
    step();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL idle_beat: busy=%b in_ready=%b want 0 0", busy, in_ready);
    end
    run_neuron("handshake", 16'h0000, 16'h0100, 16'h0100, 1'b1, 1'b1, 16'h0400);
  endtask

  task automatic test_reset_mid();
    start = 1'b1; bias = 16'h0300;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 16'h0200; in_weight = 16'h0300;
      step();
    end
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 16'h0000 || ready !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: out=%h ready=%b in_ready=%b busy=%b want 0000 0 0 0", out, ready, in_ready, busy);
    end
    #2 rst_n = 1'b1;
    step();
    prev_out = 16'h0000;
    run_neuron("post_reset", 16'h0000, 16'h0100, 16'h0100, 1'b0, 1'b0, 16'h0400);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_truncation();
    test_handshake();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
